intro_sweep_driver: RTL and testbench

Stimulus-and-capture companion for the intro combinational/latch datapath. It drives the datapath's four inputs (A, B, C, D) through all 16 input vectors, waits a programmable settle time per vector, and samples the three outputs (X, Y, Z) into a 16-bit multiple-input signature register (MISR). A start/done handshake lets a bench or self-test controller run a sweep and read back one signature word.

---
 rtl/intro_pkg.sv | 28 ++
 rtl/intro_misr.sv | 27 ++
 rtl/intro_sweep_driver.sv | 103 ++++++++++
 tb/tb_intro_sweep_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intro_pkg.sv
// Shared types and constants for the intro sweep/capture blocks.
package intro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned MISR_W = 16;
  localparam int unsigned VEC_W  = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [MISR_W-1:0] POLY_DEFAULT = 16'h1021;
  localparam logic [MISR_W-1:0] SEED_DEFAULT = 16'hFFFF;

  // One MISR step: shift left, fold back the polynomial on MSB, xor in the 3-bit sample.
  function automatic logic [MISR_W-1:0] misr_next(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] poly,
    input logic [2:0]        din
  );
    return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ {{(MISR_W-3){1'b0}}, din};
  endfunction

endpackage

// File: rtl/intro_misr.sv
// 16-bit multiple-input signature register with synchronous load and enable.
module intro_misr
  import intro_pkg::*;
#(
  parameter logic [MISR_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [MISR_W-1:0] seed,
  input  logic              enable,
  input  logic [2:0]        din,
  output logic [MISR_W-1:0] sig
);

  // Signature register: load wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig <= '0;
    end else if (load) begin
      sig <= seed;
    end else if (enable) begin
      sig <= misr_next(sig, POLY, din);
    end
  end

endmodule

// File: rtl/intro_sweep_driver.sv
// Drives all 16 ABCD vectors, waits a settle time per vector and compresses XYZ into a MISR.
module intro_sweep_driver
  import intro_pkg::*;
#(
  parameter int unsigned       SETTLE_CYC = 4,
  parameter logic [MISR_W-1:0] SEED       = SEED_DEFAULT,
  parameter logic [MISR_W-1:0] POLY       = POLY_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  input  logic              X,
  input  logic              Y,
  input  logic              Z,
  output logic              Busy,
  output logic              Done,
  output logic [MISR_W-1:0] Signature
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_next;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] cnt;
  logic             settle_end;
  logic             last_vec;
  logic             misr_load;
  logic             misr_en;

  assign settle_end = (cnt == SETTLE_LAST);
  assign last_vec   = (vec == '1);
  assign misr_load  = (state == IDLE) && Start;
  assign misr_en    = (state == SAMPLE);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    Busy       = (state != IDLE);
    Done       = 1'b0;
    case (state)
      IDLE:    if (Start) state_next = DRIVE;
      DRIVE:   state_next = SETTLE;
      SETTLE:  if (settle_end) state_next = SAMPLE;
      SAMPLE:  state_next = last_vec ? DONE : DRIVE;
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Vector counter, settle counter and registered ABCD drive.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vec          <= '0;
      cnt          <= '0;
      {A, B, C, D} <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            vec <= '0;
            cnt <= '0;
          end
        end
        DRIVE: begin
          {A, B, C, D} <= vec;
          cnt          <= '0;
        end
        SETTLE:  cnt <= settle_end ? '0 : cnt + 1'b1;
        SAMPLE:  if (!last_vec) vec <= vec + 1'b1;
        default: ;
      endcase
    end
  end

  intro_misr #(
    .POLY(POLY)
  ) u_misr (
    .clk   (Clk),
    .reset (Reset),
    .load  (misr_load),
    .seed  (SEED),
    .enable(misr_en),
    .din   ({X, Y, Z}),
    .sig   (Signature)
  );

endmodule

// File: tb/tb_intro_sweep_driver.sv
// Scoreboard bench for intro_sweep_driver: three instances (settle 4, 1, 15).
module tb_intro_sweep_driver;

  localparam int unsigned N = 3;

  typedef struct {
    logic [15:0] sig;
    int unsigned len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start    [N];
  logic        loopback [N];
  exp_t        sb       [N][$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Hand-derived sweep lengths 16*(2+SETTLE_CYC).
  function automatic int unsigned len_of(input int unsigned i);
    case (i)
      0:       return 96;
      1:       return 48;
      default: return 272;
    endcase
  endfunction

  // Reference MISR for loopback X=A, Y=B, Z=C over vectors 0..15.
  function automatic logic [15:0] model_loop_sig();
    logic [15:0] m;
    logic [3:0]  v4;
    logic [2:0]  t;
    m = 16'hFFFF;
    for (int v = 0; v < 16; v++) begin
      v4 = 4'(v);
      t  = v4[3:1];
      m  = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {13'b0, t};
    end
    return m;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_dut
    localparam int unsigned S = (i == 0) ? 4 : (i == 1) ? 1 : 15;
    logic        a, b, c, d, x, y, z, busy, done;
    logic [15:0] signature;
    int unsigned drive_cyc = 0;
    logic        busy_q = 1'b0;
    exp_t        e;

    assign x = loopback[i] & a;
    assign y = loopback[i] & b;
    assign z = loopback[i] & c;

    intro_sweep_driver #(.SETTLE_CYC(S)) dut (
      .Clk      (clk),
      .Reset    (rst),
      .Start    (start[i]),
      .A        (a),
      .B        (b),
      .C        (c),
      .D        (d),
      .X        (x),
      .Y        (y),
      .Z        (z),
      .Busy     (busy),
      .Done     (done),
      .Signature(signature)
    );

    // Monitor: timestamps DRIVE entry, pops the scoreboard on every Done.
    always @(negedge clk) begin
      if (rst) begin
        busy_q = 1'b0;
      end else begin
        if (busy && !busy_q) drive_cyc = cyc;
        busy_q = busy;
        if (done) begin
          if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done[%0d] actual=1 required=0", i);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("signature[%0d]", i), 32'(signature), 32'(e.sig));
            check($sformatf("sweep_len[%0d]", i), cyc - drive_cyc, e.len);
          end
        end
      end
    end
  end

  task automatic expect_sweep(input int unsigned i, input bit loop);
    exp_t e;
    e.sig = loop ? model_loop_sig() : 16'h1D0F;
    e.len = len_of(i);
    sb[i].push_back(e);
  endtask

  task automatic pulse_start(input int unsigned i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_drained(input int unsigned i, input int unsigned budget);
    int unsigned n = 0;
    while (sb[i].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb[i].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout[%0d] pending=%0d required=0", i, sb[i].size());
      sb[i].delete();
    end
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_busy"}, 32'(g_dut[0].busy), 0);
    check({tag, "_done"}, 32'(g_dut[0].done), 0);
    check({tag, "_abcd"}, 32'({g_dut[0].a, g_dut[0].b, g_dut[0].c, g_dut[0].d}), 0);
    check({tag, "_sig"}, 32'(g_dut[0].signature), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    rst = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      start[i]    = 1'b0;
      loopback[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values, idle with Start low.
    repeat (5) begin
      @(negedge clk);
      check_idle0("reset");
    end

    // All-zero datapath outputs.
    expect_sweep(0, 1'b0);
    pulse_start(0);
    wait_drained(0, 200);

    // Loopback: ABCD steps 0..15, each held 6 cycles.
    loopback[0] = 1'b1;
    expect_sweep(0, 1'b1);
    pulse_start(0);
    check("drive_busy", 32'(g_dut[0].busy), 1);
    for (int j = 0; j < 96; j++) begin
      @(negedge clk);
      check($sformatf("abcd_j%0d", j), 32'({g_dut[0].a, g_dut[0].b, g_dut[0].c, g_dut[0].d}), 32'(j / 6));
    end
    wait_drained(0, 10);

    // Start mid-sweep is ignored; any extra Done is flagged by the monitor.
    expect_sweep(0, 1'b1);
    pulse_start(0);
    repeat (29) @(negedge clk);
    pulse_start(0);
    wait_drained(0, 200);
    repeat (120) @(negedge clk);

    // Start held through DONE re-triggers from the following IDLE cycle.
    loopback[0] = 1'b0;
    expect_sweep(0, 1'b0);
    expect_sweep(0, 1'b0);
    start[0] = 1'b1;
    @(negedge clk);
    n = 0;
    while (!g_dut[0].done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_done_seen", 32'(g_dut[0].done), 1);
    check("hold_done_busy", 32'(g_dut[0].busy), 1);
    @(negedge clk);
    check("hold_idle_busy", 32'(g_dut[0].busy), 0);
    @(negedge clk);
    check("hold_restart_busy", 32'(g_dut[0].busy), 1);
    start[0] = 1'b0;
    wait_drained(0, 200);

    // Reset during vector 7 SETTLE aborts without Done.
    loopback[0] = 1'b1;
    expect_sweep(0, 1'b1);
    pulse_start(0);
    repeat (44) @(negedge clk);
    check("mid_abcd", 32'({g_dut[0].a, g_dut[0].b, g_dut[0].c, g_dut[0].d}), 7);
    check("mid_busy", 32'(g_dut[0].busy), 1);
    sb[0].delete();
    rst = 1'b1;
    @(negedge clk);
    check_idle0("abort");
    rst = 1'b0;
    repeat (120) @(negedge clk);
    expect_sweep(0, 1'b1);
    pulse_start(0);
    wait_drained(0, 200);

    // Settle extremes.
    loopback[1] = 1'b1;
    loopback[2] = 1'b1;
    expect_sweep(1, 1'b1);
    expect_sweep(2, 1'b1);
    start[1] = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    start[2] = 1'b0;
    wait_drained(1, 400);
    wait_drained(2, 400);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
